// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared raster phase type and 640x480@60 default timing
package video_pkg;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } sync_phase_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

endpackage

// File: rtl/video_axis_counter.sv
// rtl/video_axis_counter.sv - one raster axis: position counter plus porch/sync phase FSM
module video_axis_counter
   import video_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FRONT  = DEF_H_FRONT,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BACK   = DEF_H_BACK,
   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK,
   localparam int W     = $clog2(TOTAL)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   output logic [W-1:0] count,
   output sync_phase_t phase,
   output logic        wrap
);

   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] FRONT_AT = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_AT  = W'(ACTIVE + FRONT);
   localparam logic [W-1:0] BACK_AT  = W'(ACTIVE + FRONT + SYNC);

   logic        at_end;
   logic [W-1:0] count_d;
   sync_phase_t phase_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         phase <= PH_ACTIVE;
      end else begin
         count <= count_d;
         phase <= phase_d;
      end
   end

   // Wrap takes priority so a zero-length back porch (BACK_AT == TOTAL) never aliases.
   always_comb begin
      at_end  = (count == LAST);
      wrap    = advance && at_end;
      count_d = count;
      phase_d = phase;
      if (advance) begin
         count_d = at_end ? '0 : count + 1'b1;
         case (phase)
            PH_ACTIVE: if (count_d == FRONT_AT) phase_d = (FRONT != 0) ? PH_FRONT : PH_SYNC;
            PH_FRONT:  if (count_d == SYNC_AT) phase_d = PH_SYNC;
            PH_SYNC: begin
               if (at_end)                    phase_d = PH_ACTIVE;
               else if (count_d == BACK_AT)   phase_d = PH_BACK;
            end
            PH_BACK:   if (at_end) phase_d = PH_ACTIVE;
            default:   phase_d = PH_ACTIVE;
         endcase
      end
   end

endmodule

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster timing generator; VIDEO_TIMING_FRAME_COUNT_EN adds frame_count
module video_timing
   import video_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
   localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_en,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   ,
   output logic [15:0]   frame_count
`endif
);

   logic [XW-1:0] hc;
   logic [YW-1:0] vc;
   sync_phase_t   h_phase;
   sync_phase_t   v_phase;
   logic          h_wrap;
   logic          v_wrap;
   logic          frame_pending;

   video_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) u_h (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (pix_en),
      .count   (hc),
      .phase   (h_phase),
      .wrap    (h_wrap)
   );

   video_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) u_v (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (h_wrap),
      .count   (vc),
      .phase   (v_phase),
      .wrap    (v_wrap)
   );

   // Outputs trail hc/vc by one enabled edge; frame_pending marks that hc/vc sit at 0,0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x             <= '0;
         y             <= '0;
         de            <= 1'b0;
         hsync         <= ~HSYNC_POL;
         vsync         <= ~VSYNC_POL;
         line_start    <= 1'b0;
         frame_start   <= 1'b0;
         frame_pending <= 1'b1;
      end else if (pix_en) begin
         x             <= hc;
         y             <= vc;
         de            <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
         hsync         <= (h_phase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
         vsync         <= (v_phase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
         line_start    <= (hc == '0);
         frame_start   <= frame_pending;
         frame_pending <= v_wrap;
      end else begin
         line_start    <= 1'b0;
         frame_start   <= 1'b0;
      end
   end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   logic first_seen;

   // The first frame after reset reads 0; later frame starts bump the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count <= '0;
         first_seen  <= 1'b0;
      end else if (pix_en && frame_pending) begin
         first_seen <= 1'b1;
         if (first_seen) frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - directed checks of video_timing (default, small, zero-porch geometries)
module tb_video_timing;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pix_en = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // A: default 640x480 timing
   logic [9:0] a_x;
   logic [8:0] a_y;
   logic a_de, a_hs, a_vs, a_ls, a_fs;
   // B: small geometry 10/2/3/1 x 5/1/2/1 (16 x 9)
   logic [3:0] b_x;
   logic [3:0] b_y;
   logic b_de, b_hs, b_vs, b_ls, b_fs;
   // C: zero porches 8/0/3/0 x 4/0/2/1 (11 x 7), active-high syncs
   logic [3:0] c_x;
   logic [2:0] c_y;
   logic c_de, c_hs, c_vs, c_ls, c_fs;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   logic [15:0] a_fc, b_fc, c_fc;
`endif

   video_timing dut_a (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .x(a_x), .y(a_y), .de(a_de), .hsync(a_hs), .vsync(a_vs),
      .line_start(a_ls), .frame_start(a_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      , .frame_count(a_fc)
`endif
   );

   video_timing #(
      .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
      .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .x(b_x), .y(b_y), .de(b_de), .hsync(b_hs), .vsync(b_vs),
      .line_start(b_ls), .frame_start(b_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      , .frame_count(b_fc)
`endif
   );

   video_timing #(
      .H_ACTIVE(8), .H_FRONT(0), .H_SYNC(3), .H_BACK(0),
      .V_ACTIVE(4), .V_FRONT(0), .V_SYNC(2), .V_BACK(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) dut_c (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .x(c_x), .y(c_y), .de(c_de), .hsync(c_hs), .vsync(c_vs),
      .line_start(c_ls), .frame_start(c_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      , .frame_count(c_fc)
`endif
   );

   // Leaves the bench at a negedge with rst_n just released and pix_en=1.
   task automatic apply_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      pix_en = 1'b1;
      @(negedge clk);
      rst_n  = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      pix_en = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_a: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want 0 0 0 1 1 0 0",
                  a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs);
      end
      vectors++;
      if ({c_hs, c_vs} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_c_pol: got hs=%b vs=%b, want 0 0", c_hs, c_vs);
      end
   endtask

   task automatic test_default_lines();
      int ex, ey, hs_low, hs_first;
      logic e_de, e_hs, e_ls, e_fs;
      hs_low   = 0;
      hs_first = -1;
      apply_reset();
      for (int k = 1; k <= 1700; k++) begin
         @(negedge clk);
         ex   = (k - 1) % 800;
         ey   = (k - 1) / 800;
         e_de = (ex < 640) && (ey < 480);
         e_hs = !((ex >= 656) && (ex < 752));
         e_ls = (ex == 0);
         e_fs = (ex == 0) && (ey == 0);
         vectors++;
         if ({a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs} !== {10'(ex), 9'(ey), e_de, e_hs, 1'b1, e_ls, e_fs}) begin
            miscompares++;
            $display("FAIL default_line k=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want x=%0d y=%0d de=%b hs=%b vs=1 ls=%b fs=%b",
                     k, a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs, ex, ey, e_de, e_hs, e_ls, e_fs);
         end
         if (ey == 0 && a_hs == 1'b0) begin
            if (hs_first < 0) hs_first = int'(a_x);
            hs_low++;
         end
      end
      vectors++;
      if (hs_low != 96 || hs_first != 656) begin
         miscompares++;
         $display("FAIL hsync_width: got %0d clks from x=%0d, want 96 clks from x=656", hs_low, hs_first);
      end
   endtask

   task automatic test_pix_en();
      int en_cnt, ex, ls_cnt;
      logic e_ls;
      en_cnt = 0;
      ls_cnt = 0;
      apply_reset();
      for (int k = 0; k < 1700; k++) begin
         @(negedge clk);
         if (k % 2 == 0) en_cnt++;
         ex   = (en_cnt - 1) % 800;
         e_ls = (k % 2 == 0) && (ex == 0);
         if (a_ls) ls_cnt++;
         vectors++;
         if ({a_x, a_ls} !== {10'(ex), e_ls}) begin
            miscompares++;
            $display("FAIL pix_en_step k=%0d: got x=%0d ls=%b, want x=%0d ls=%b", k, a_x, a_ls, ex, e_ls);
         end
         pix_en = ((k + 1) % 2 == 0);
      end
      pix_en = 1'b1;
      vectors++;
      if (ls_cnt != 2) begin
         miscompares++;
         $display("FAIL pix_en_line_start_count: got %0d, want 2", ls_cnt);
      end
   endtask

   task automatic test_small_frame();
      int ex, ey, last_fs, fs_cnt, vs_low;
      logic e_de, e_hs, e_vs, e_ls, e_fs;
      last_fs = -1;
      fs_cnt  = 0;
      vs_low  = 0;
      apply_reset();
      for (int k = 1; k <= 3 * 144 + 1; k++) begin
         @(negedge clk);
         ex   = (k - 1) % 16;
         ey   = ((k - 1) / 16) % 9;
         e_de = (ex < 10) && (ey < 5);
         e_hs = !((ex >= 12) && (ex < 15));
         e_vs = !((ey >= 6) && (ey < 8));
         e_ls = (ex == 0);
         e_fs = (ex == 0) && (ey == 0);
         vectors++;
         if ({b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs} !== {4'(ex), 4'(ey), e_de, e_hs, e_vs, e_ls, e_fs}) begin
            miscompares++;
            $display("FAIL small_frame k=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                     k, b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs, ex, ey, e_de, e_hs, e_vs, e_ls, e_fs);
         end
         if (k <= 144 && b_vs == 1'b0) vs_low++;
         if (b_fs) begin
            if (last_fs >= 0) begin
               vectors++;
               if (k - last_fs != 144) begin
                  miscompares++;
                  $display("FAIL frame_period: got %0d clks, want 144", k - last_fs);
               end
            end
            last_fs = k;
            fs_cnt++;
         end
      end
      vectors++;
      if (vs_low != 32 || fs_cnt != 4) begin
         miscompares++;
         $display("FAIL vsync_width: got %0d low clks / %0d frame starts, want 32 / 4", vs_low, fs_cnt);
      end
   endtask

   task automatic test_zero_porch();
      int ex, ey;
      logic e_de, e_hs, e_vs, e_ls;
      apply_reset();
      for (int k = 1; k <= 2 * 77 + 1; k++) begin
         @(negedge clk);
         ex   = (k - 1) % 11;
         ey   = ((k - 1) / 11) % 7;
         e_de = (ex < 8) && (ey < 4);
         e_hs = (ex >= 8);
         e_vs = (ey >= 4) && (ey < 6);
         e_ls = (ex == 0);
         vectors++;
         if ({c_x, c_y, c_de, c_hs, c_vs, c_ls} !== {4'(ex), 3'(ey), e_de, e_hs, e_vs, e_ls}) begin
            miscompares++;
            $display("FAIL zero_porch k=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b",
                     k, c_x, c_y, c_de, c_hs, c_vs, c_ls, ex, ey, e_de, e_hs, e_vs, e_ls);
         end
      end
   endtask

   task automatic test_async_reset();
      int t;
      t = 0;
      apply_reset();
      while (!(b_x == 4'd5 && b_y == 4'd3) && t < 400) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (t >= 400) begin
         miscompares++;
         $display("FAIL async_reach: x=%0d y=%0d, want x=5 y=3 within 400 clks", b_x, b_y);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs} !== {4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset_b: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want 0 0 0 1 1 0 0",
                  b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs);
      end
      vectors++;
      if ({a_x, a_de, c_hs, c_vs} !== {10'd0, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset_ac: got a_x=%0d a_de=%b c_hs=%b c_vs=%b, want 0 0 0 0", a_x, a_de, c_hs, c_vs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({b_x, b_y, b_de, b_ls, b_fs} !== {4'd0, 4'd0, 1'b1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL restart: got x=%0d y=%0d de=%b ls=%b fs=%b, want 0 0 1 1 1", b_x, b_y, b_de, b_ls, b_fs);
      end
   endtask

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   task automatic test_frame_count();
      int fidx;
      fidx = 0;
      apply_reset();
      for (int k = 1; k <= 3 * 144 + 2; k++) begin
         @(negedge clk);
         if (b_fs) begin
            vectors++;
            if (b_fc !== 16'(fidx)) begin
               miscompares++;
               $display("FAIL frame_count: got %0d at frame %0d, want %0d", b_fc, fidx, fidx);
            end
            fidx++;
         end
      end
      vectors++;
      if (fidx != 4) begin
         miscompares++;
         $display("FAIL frame_count_pulses: got %0d, want 4", fidx);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_default_lines();
      test_pix_en();
      test_small_frame();
      test_zero_porch();
      test_async_reset();
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      test_frame_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
